// File: rtl/xmit_arbiter_pkg.sv
// rtl/xmit_arbiter_pkg.sv - shared encodings for the transmit arbiter
// State codes, requester slot indices and the default stall limit.
package xmit_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_SEND    = 2'd2,
    ST_WAIT    = 2'd3
  } state_t;

  localparam int REQ_META        = 0;
  localparam int REQ_DUMP        = 1;
  localparam int REQ_ID          = 2;
  localparam int DEFAULT_TIMEOUT = 1023;
endpackage

// File: rtl/xmit_arbiter_rr_pick.sv
// rtl/xmit_arbiter_rr_pick.sv - combinational round-robin picker
// Searches upward from i_ptr+1 with wrap; returns a one-hot winner.
module rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_onehot,
  output logic                 o_valid
);
  localparam int PW = $clog2(N);

  logic [PW:0] w_idx;
  logic        w_found;

  // ptr <= N-1 and k <= N, so one conditional subtract is enough to wrap
  always_comb begin
    o_onehot = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(N)) w_idx = w_idx - (PW+1)'(N);
      if (!w_found && i_req[w_idx[PW-1:0]]) begin
        o_onehot[w_idx[PW-1:0]] = 1'b1;
        w_found                 = 1'b1;
      end
    end
  end

  assign o_valid = |i_req;
endmodule

// File: rtl/xmit_arbiter.sv
// rtl/xmit_arbiter.sv - round-robin owner of the spi_transmitter datapath
// Holds a grant for a whole packet, paces words on tx_idle, watchdog revokes stalls.
module xmit_arbiter
  import xmit_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CW      = 16
) (
  input  logic                 clock,
  input  logic                 extReset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      wr,
  input  logic [32*NREQ-1:0]   wr_data,
  input  logic [4*NREQ-1:0]    wr_disabled,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      ready,
  input  logic                 tx_idle,
  output logic                 tx_send,
  output logic [31:0]          tx_data,
  output logic [3:0]           tx_disabled,
  output logic                 timeout
);
  localparam int            PW      = $clog2(NREQ);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  state_t          r_state;
  logic [NREQ-1:0] r_grant;
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_wdog;
  logic            r_send;
  logic            r_timeout;
  logic            r_rel_pend;
  logic            r_holdoff;
  logic [31:0]     r_data;
  logic [3:0]      r_dis;

  logic [NREQ-1:0] w_pick;
  logic            w_pick_valid;
  logic [PW-1:0]   w_pick_idx;
  logic            w_own_req;
  logic            w_own_wr;
  logic [31:0]     w_own_data;
  logic [3:0]      w_own_dis;

  rr_pick #(.N(NREQ)) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick),
    .o_valid  (w_pick_valid)
  );

  always_comb begin
    w_pick_idx = '0;
    w_own_data = '0;
    w_own_dis  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick[i]) w_pick_idx = PW'(i);
      if (r_grant[i]) begin
        w_own_data = wr_data[32*i +: 32];
        w_own_dis  = wr_disabled[4*i +: 4];
      end
    end
  end

  assign ready     = (r_state == ST_GRANTED && tx_idle) ? r_grant : '0;
  assign w_own_req = |(req & r_grant);
  assign w_own_wr  = |(wr & ready);

  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_ptr      <= PW'(NREQ - 1);
      r_wdog     <= '0;
      r_send     <= 1'b0;
      r_timeout  <= 1'b0;
      r_rel_pend <= 1'b0;
      r_holdoff  <= 1'b0;
      r_data     <= '0;
      r_dis      <= '0;
    end else begin
      r_send    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid && tx_idle) begin
            r_grant    <= w_pick;
            r_ptr      <= w_pick_idx;
            r_wdog     <= '0;
            r_rel_pend <= 1'b0;
            r_state    <= ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          // a write in the same cycle as the req drop still goes out; release waits for WAIT exit
          if (w_own_wr) begin
            r_data     <= w_own_data;
            r_dis      <= w_own_dis;
            r_send     <= 1'b1;
            r_rel_pend <= !w_own_req;
            r_state    <= ST_SEND;
          end else if (!w_own_req) begin
            r_grant <= '0;
            r_state <= ST_IDLE;
          end else if (r_wdog == WD_LAST) begin
            r_grant   <= '0;
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        ST_SEND: begin
          r_holdoff <= 1'b1;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          // transmitter needs a cycle to raise busy, so tx_idle is not trusted right away
          if (r_holdoff) begin
            r_holdoff <= 1'b0;
          end else if (tx_idle) begin
            r_wdog <= '0;
            if (w_own_req && !r_rel_pend) begin
              r_state <= ST_GRANTED;
            end else begin
              r_grant    <= '0;
              r_rel_pend <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign tx_send     = r_send;
  assign tx_data     = r_data;
  assign tx_disabled = r_dis;
  assign timeout     = r_timeout;
endmodule
